seq_array_mult: RTL and testbench

- Parametrised iterative shift-add multiplier; successor to the fixed 8x8 combinational array multiplier.
- Trades area for latency: one partial product per clock.
- Adds signed/unsigned mode per transaction and valid/ready handshakes on input and output.
- Sits between operand producers and accumulators/datapath stages that can tolerate multi-cycle latency.

---
 rtl/seq_array_mult.sv | 138 +++++++++++++
 tb/tb_seq_array_mult.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_array_mult.sv
// Iterative shift-add multiplier: one partial product per clock, optional
// two's-complement operands, valid/ready handshakes on both sides.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. in_ready is high only in IDLE, out_valid only in DONE; p stays
// stable while out_valid is high and keeps its value after the handshake.
module seq_array_mult #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 signed_mode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   p,
    output logic                 busy
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [WIDTH-1:0]    ma;
    logic [WIDTH-1:0]    mb;
    logic                neg;
    logic [CW-1:0]       count;
    logic [2*WIDTH-1:0]  acc;
    logic [2*WIDTH-1:0]  acc_sum;
    logic [2*WIDTH-1:0]  partial;
    logic                last_step;
    logic [WIDTH-1:0]    a_mag;
    logic [WIDTH-1:0]    b_mag;

    // The final step is the one that consumes multiplier bit WIDTH-1.
    assign last_step = (count == CW'(WIDTH - 1));

    // Operand magnitudes; |-2^(WIDTH-1)| still fits in WIDTH unsigned bits.
    always_comb begin
        a_mag = (signed_mode && a[WIDTH-1]) ? -a : a;
        b_mag = (signed_mode && b[WIDTH-1]) ? -b : b;
    end

    // Partial product for the current multiplier bit and the running sum.
    always_comb begin
        partial = '0;
        if (mb[0]) begin
            partial = {{WIDTH{1'b0}}, ma} << count;
        end
        acc_sum = acc + partial;
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and state-decoded handshake outputs.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_next = CALC;
                end
            end
            CALC: begin
                busy = 1'b1;
                if (last_step) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath: capture magnitudes on accept, one shift-add step per CALC cycle,
    // apply the sign on the last step. No early exit, so latency is fixed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ma    <= '0;
            mb    <= '0;
            neg   <= 1'b0;
            count <= '0;
            acc   <= '0;
            p     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        ma    <= a_mag;
                        mb    <= b_mag;
                        neg   <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
                        count <= '0;
                        acc   <= '0;
                    end
                end
                CALC: begin
                    acc   <= acc_sum;
                    mb    <= mb >> 1;
                    count <= count + CW'(1);
                    if (last_step) begin
                        p <= neg ? -acc_sum : acc_sum;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_array_mult.sv
// Directed bench for seq_array_mult: an 8-bit instance for hand-computed
// vectors and handshake corners, plus a 16-bit instance swept against a
// reference product.
`timescale 1ns/1ps
module tb_seq_array_mult;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- 8-bit DUT ----------------
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        sm;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] p;
  logic        busy;

  seq_array_mult #(.WIDTH(8)) dut8 (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .signed_mode(sm),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .p          (p),
    .busy       (busy)
  );

  // ---------------- 16-bit DUT ----------------
  logic        in_valid16;
  logic        in_ready16;
  logic [15:0] a16;
  logic [15:0] b16;
  logic        sm16;
  logic        out_valid16;
  logic        out_ready16;
  logic [31:0] p16;
  logic        busy16;

  seq_array_mult #(.WIDTH(16)) dut16 (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid16),
    .in_ready   (in_ready16),
    .a          (a16),
    .b          (b16),
    .signed_mode(sm16),
    .out_valid  (out_valid16),
    .out_ready  (out_ready16),
    .p          (p16),
    .busy       (busy16)
  );

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_bad = 0;
  logic [15:0] exp_q[$];
  int hs_count = 0;

  // Completed output handshakes on the 8-bit DUT, sampled mid-cycle.
  always @(negedge clk) begin
    if (out_valid && out_ready) hs_count++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref16(input logic [15:0] x, input logic [15:0] y, input logic s);
    longint vx;
    longint vy;
    vx = s ? longint'($signed(x)) : longint'(x);
    vy = s ? longint'($signed(y)) : longint'(y);
    return 32'(vx * vy);
  endfunction

  // ---------------- driver tasks ----------------
  // One 8-bit transaction: accept, measure latency, optional backpressure
  // (with optional ignored in_valid pokes), then the output handshake.
  task automatic op8(input string tag, input logic [7:0] x, input logic [7:0] y,
                     input logic s, input logic [15:0] e, input int hold, input bit poke);
    int n;
    int lat;
    bit ir_hi;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    check({tag, " ready"}, 32'(in_ready), 32'd1);
    a = x; b = y; sm = s; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check({tag, " busy"}, 32'(busy), 32'd1);
    lat = 0;
    ir_hi = 1'b0;
    while (!out_valid && lat < 40) begin
      if (in_ready) ir_hi = 1'b1;
      @(posedge clk); #1; lat++;
    end
    check({tag, " latency"}, 32'(lat), 32'd8);
    check({tag, " in_ready low"}, 32'(ir_hi | in_ready), 32'd0);
    check({tag, " p"}, 32'(p), 32'(e));
    for (int k = 0; k < hold; k++) begin
      if (poke) begin
        in_valid = 1'b1; a = 8'd3; b = 8'd3; sm = 1'b0;
      end
      @(posedge clk); #1;
      check({tag, " held"}, {15'd0, out_valid, p}, {15'd0, 1'b1, e});
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, " idle after hs"}, {29'd0, out_valid, in_ready, busy}, {29'd0, 1'b0, 1'b1, 1'b0});
    check({tag, " p kept"}, 32'(p), 32'(e));
  endtask

  // One 16-bit transaction; out_ready16 is tied high.
  task automatic op16(input string tag, input logic [15:0] x, input logic [15:0] y, input logic s);
    int n;
    int lat;
    n = 0;
    while (!in_ready16 && n < 50) begin
      @(posedge clk); #1; n++;
    end
    a16 = x; b16 = y; sm16 = s; in_valid16 = 1'b1;
    @(posedge clk); #1;
    in_valid16 = 1'b0;
    lat = 0;
    while (!out_valid16 && lat < 60) begin
      @(posedge clk); #1; lat++;
    end
    check({tag, " latency"}, 32'(lat), 32'd16);
    check({tag, " p"}, p16, ref16(x, y, s));
  endtask

  // ---------------- directed sequence ----------------
  logic [7:0]  bb_a [3];
  logic [7:0]  bb_b [3];
  logic        bb_s [3];
  logic [15:0] bb_e [3];
  logic [15:0] corners [5];
  longint      t_acc [3];

  initial begin
    int n;
    int hs0;
    rst_n = 1'b0;
    in_valid = 1'b0; a = '0; b = '0; sm = 1'b0; out_ready = 1'b0;
    in_valid16 = 1'b0; a16 = '0; b16 = '0; sm16 = 1'b0; out_ready16 = 1'b1;

    // Reset state
    #1;
    check("reset outputs", {28'd0, in_ready, out_valid, busy, 1'b0}, {28'd0, 1'b1, 1'b0, 1'b0, 1'b0});
    check("reset p", 32'(p), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Unsigned and signed vectors
    op8("unsigned max",   8'hFF, 8'hFF, 1'b0, 16'hFE01, 0, 1'b0);
    op8("signed -3*5",    8'hFD, 8'h05, 1'b1, 16'hFFF1, 0, 1'b0);
    op8("signed min*min", 8'h80, 8'h80, 1'b1, 16'h4000, 0, 1'b0);
    op8("unsigned 80*80", 8'h80, 8'h80, 1'b0, 16'h4000, 0, 1'b0);
    op8("unsigned ff*2",  8'hFF, 8'h02, 1'b0, 16'h01FE, 0, 1'b0);
    op8("signed -1*2",    8'hFF, 8'h02, 1'b1, 16'hFFFE, 0, 1'b0);
    op8("signed zero",    8'h00, 8'hFF, 1'b1, 16'h0000, 0, 1'b0);
    op8("signed 127*-128",8'h7F, 8'h80, 1'b1, 16'hC080, 0, 1'b0);

    // Backpressure with ignored in_valid pokes
    op8("backpressure",   8'd12, 8'd13, 1'b0, 16'd156, 5, 1'b1);

    // Reset in the middle of CALC (count = 3)
    a = 8'd100; b = 8'd100; sm = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("async reset outputs", {29'd0, out_valid, in_ready, busy}, {29'd0, 1'b0, 1'b1, 1'b0});
    check("async reset p", 32'(p), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    op8("after reset 7*9", 8'd7, 8'd9, 1'b0, 16'd63, 0, 1'b0);

    // Back-to-back with in_valid held and out_ready tied high
    bb_a[0] = 8'd10;  bb_b[0] = 8'd20; bb_s[0] = 1'b0; bb_e[0] = 16'd200;
    bb_a[1] = 8'hF0;  bb_b[1] = 8'h03; bb_s[1] = 1'b1; bb_e[1] = 16'hFFD0;
    bb_a[2] = 8'd200; bb_b[2] = 8'd3;  bb_s[2] = 1'b0; bb_e[2] = 16'd600;
    hs0 = hs_count;
    out_ready = 1'b1;
    a = bb_a[0]; b = bb_b[0]; sm = bb_s[0]; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      n = 0;
      while (!in_ready && n < 50) begin
        @(posedge clk); #1; n++;
      end
      @(posedge clk); #1;
      t_acc[i] = longint'($time);
      exp_q.push_back(bb_e[i]);
      if (i < 2) begin
        a = bb_a[i+1]; b = bb_b[i+1]; sm = bb_s[i+1];
      end else begin
        in_valid = 1'b0;
      end
      n = 0;
      while (!out_valid && n < 40) begin
        @(posedge clk); #1; n++;
      end
      check("b2b out_valid", 32'(out_valid), 32'd1);
      check("b2b p", 32'(p), 32'(exp_q.pop_front()));
    end
    @(posedge clk); #1;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("b2b spacing 0-1", 32'((t_acc[1] - t_acc[0]) / 10), 32'd10);
    check("b2b spacing 1-2", 32'((t_acc[2] - t_acc[1]) / 10), 32'd10);
    check("b2b handshakes", 32'(hs_count - hs0), 32'd3);
    check("b2b final idle", {30'd0, in_ready, busy}, {30'd0, 1'b1, 1'b0});

    // 16-bit corners in both modes
    corners[0] = 16'h0000; corners[1] = 16'h0001; corners[2] = 16'hFFFF;
    corners[3] = 16'h8000; corners[4] = 16'h7FFF;
    for (int i = 0; i < 5; i++) begin
      for (int j = 0; j < 5; j++) begin
        op16("w16 corner u", corners[i], corners[j], 1'b0);
        op16("w16 corner s", corners[i], corners[j], 1'b1);
      end
    end

    // 16-bit random operands and modes
    for (int i = 0; i < 1000; i++) begin
      op16("w16 random", 16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)),
           1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
